// File: rtl/axi_wdata_mux_ctrl.sv
// W-channel router: locks the queue-head master's W port onto the slave side until WLAST.
// Build option W_REG_SLICE_EN inserts a two-entry skid buffer in front of the M_W* outputs.
module axi_wdata_mux_ctrl #(
    parameter int Masters_Num = 2,
    parameter int ID_Size     = $clog2(Masters_Num),
    parameter int Data_Width  = 32,
    parameter int Cnt_Width   = 9
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              Master_Valid,
    input  logic [ID_Size-1:0]                Write_Data_Master,
    output logic                              Write_Data_Finsh,
    input  logic [Masters_Num*Data_Width-1:0] S_WDATA,
    input  logic [Masters_Num*Data_Width/8-1:0] S_WSTRB,
    input  logic [Masters_Num-1:0]            S_WLAST,
    input  logic [Masters_Num-1:0]            S_WVALID,
    output logic [Masters_Num-1:0]            S_WREADY,
    output logic [Data_Width-1:0]             M_WDATA,
    output logic [Data_Width/8-1:0]           M_WSTRB,
    output logic                              M_WLAST,
    output logic                              M_WVALID,
    input  logic                              M_WREADY,
    output logic [Cnt_Width-1:0]              Beat_Count,
    output logic                              Busy
);
    localparam int Strb_Width = Data_Width / 8;
    localparam int Entry_W    = Data_Width + Strb_Width + 1;
    localparam logic [Cnt_Width-1:0] Cnt_One = {{(Cnt_Width-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, LOCK = 2'd1, DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [ID_Size-1:0]     sel_q, sel_d;
    logic [Cnt_Width-1:0]   cnt_q, cnt_d;
    logic                   finsh_q, finsh_d;

    logic [Data_Width-1:0]  mux_data_s;
    logic [Strb_Width-1:0]  mux_strb_s;
    logic                   mux_last_s;
    logic                   mux_valid_s;
    logic                   mux_ready_s;
    logic                   s_hs_s;

    // Master-side mux: only the latched master is visible, and only while locked
    always_comb begin
        mux_data_s  = {Data_Width{1'b0}};
        mux_strb_s  = {Strb_Width{1'b0}};
        mux_last_s  = 1'b0;
        mux_valid_s = 1'b0;
        S_WREADY    = {Masters_Num{1'b0}};
        if (state_q == LOCK) begin
            mux_data_s      = S_WDATA[sel_q*Data_Width +: Data_Width];
            mux_strb_s      = S_WSTRB[sel_q*Strb_Width +: Strb_Width];
            mux_last_s      = S_WLAST[sel_q];
            mux_valid_s     = S_WVALID[sel_q];
            S_WREADY[sel_q] = mux_ready_s;
        end else begin
            S_WREADY = {Masters_Num{1'b0}};
        end
    end

    assign s_hs_s = mux_valid_s & mux_ready_s;

    // Next-state logic for the burst lock FSM and beat counter
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        finsh_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (Master_Valid) begin
                    sel_d   = Write_Data_Master;
                    cnt_d   = {Cnt_Width{1'b0}};
                    state_d = LOCK;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK: begin
                if (s_hs_s) begin
                    if (cnt_q != {Cnt_Width{1'b1}}) begin
                        cnt_d = cnt_q + Cnt_One;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (mux_last_s) begin
                        state_d = DONE;
                        finsh_d = 1'b1;
                    end else begin
                        state_d = LOCK;
                    end
                end else begin
                    state_d = LOCK;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and control registers
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            sel_q   <= {ID_Size{1'b0}};
            cnt_q   <= {Cnt_Width{1'b0}};
            finsh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            finsh_q <= finsh_d;
        end
    end

    assign Write_Data_Finsh = finsh_q;
    assign Beat_Count       = cnt_q;
    assign Busy             = (state_q == LOCK);

`ifdef W_REG_SLICE_EN
    logic [1:0][Entry_W-1:0] buf_q, buf_d;
    logic                    wr_q, wr_d, rd_q, rd_d;
    logic [1:0]              fill_q, fill_d;
    logic                    pop_s;

    assign mux_ready_s = (fill_q != 2'd2);
    assign pop_s       = (fill_q != 2'd0) & M_WREADY;

    // Skid buffer bookkeeping; it keeps draining across DONE/IDLE
    always_comb begin
        buf_d  = buf_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        fill_d = fill_q;
        if (s_hs_s) begin
            buf_d[wr_q] = {mux_last_s, mux_strb_s, mux_data_s};
            wr_d        = ~wr_q;
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = ~rd_q;
        end else begin
            rd_d = rd_q;
        end
        case ({s_hs_s, pop_s})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    // Skid buffer storage
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            buf_q  <= {2*Entry_W{1'b0}};
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            fill_q <= 2'd0;
        end else begin
            buf_q  <= buf_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fill_q <= fill_d;
        end
    end

    // Slave-side outputs come straight from buffer registers
    always_comb begin
        M_WVALID = (fill_q != 2'd0);
        if (fill_q != 2'd0) begin
            {M_WLAST, M_WSTRB, M_WDATA} = buf_q[rd_q];
        end else begin
            {M_WLAST, M_WSTRB, M_WDATA} = {Entry_W{1'b0}};
        end
    end
`else
    assign mux_ready_s = M_WREADY;

    // Same-cycle pass-through to the slave side
    always_comb begin
        M_WVALID = mux_valid_s;
        M_WDATA  = mux_data_s;
        M_WSTRB  = mux_strb_s;
        M_WLAST  = mux_last_s;
    end
`endif

endmodule

// File: tb/tb_axi_wdata_mux_ctrl.sv
// Scoreboard bench for axi_wdata_mux_ctrl: beats are queued as expected on injection and popped on slave handshakes.
module tb_axi_wdata_mux_ctrl;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

`ifdef W_REG_SLICE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        ARESETN = 1'b0;
    logic        Master_Valid = 1'b0;
    logic [0:0]  Write_Data_Master = 1'b0;
    logic        Write_Data_Finsh;
    logic [63:0] S_WDATA = 64'd0;
    logic [7:0]  S_WSTRB = 8'd0;
    logic [1:0]  S_WLAST = 2'd0;
    logic [1:0]  S_WVALID = 2'd0;
    logic [1:0]  S_WREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WLAST;
    logic        M_WVALID;
    logic        M_WREADY = 1'b1;
    logic [8:0]  Beat_Count;
    logic        Busy;

    axi_wdata_mux_ctrl dut (
        .ACLK(clk), .ARESETN(ARESETN), .Master_Valid(Master_Valid),
        .Write_Data_Master(Write_Data_Master), .Write_Data_Finsh(Write_Data_Finsh),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .Beat_Count(Beat_Count), .Busy(Busy)
    );

    always #5 clk = ~clk;

    beat_t      mq0[$], mq1[$], exp_q[$];
    logic [0:0] qids[$];
    logic       rdy_pat[$];
    int total = 0, bad = 0, cyc = 0, hs_count = 0, finsh_count = 0;
    int last_fin = -1, prev_fin = -1, first_m = -1, first_s = -1, last_m_hs = -1, stall_hs = -1;

    function automatic beat_t mk(input logic [31:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.strb = d[3:0] ^ 4'hF;
        b.last = l;
        return b;
    endfunction

    task automatic add_beat(input int m, input logic [31:0] d, input logic l);
        if (m == 0) mq0.push_back(mk(d, l));
        else        mq1.push_back(mk(d, l));
        exp_q.push_back(mk(d, l));
    endtask

    task automatic step();
        beat_t e;
        @(negedge clk);
        Master_Valid      = (qids.size() > 0);
        Write_Data_Master = (qids.size() > 0) ? qids[0] : 1'b0;
        S_WVALID = {mq1.size() > 0, mq0.size() > 0};
        S_WDATA  = {(mq1.size() > 0) ? mq1[0].data : 32'd0, (mq0.size() > 0) ? mq0[0].data : 32'd0};
        S_WSTRB  = {(mq1.size() > 0) ? mq1[0].strb : 4'd0, (mq0.size() > 0) ? mq0[0].strb : 4'd0};
        S_WLAST  = {(mq1.size() > 0) ? mq1[0].last : 1'b0, (mq0.size() > 0) ? mq0[0].last : 1'b0};
        M_WREADY = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
        #1;
        if (S_WREADY != 2'd0) begin
            total++;
            if (qids.size() == 0 || S_WREADY !== (2'b01 << qids[0])) begin
                bad++;
                $display("FAIL wready_sel: S_WREADY=%b head_count=%0d", S_WREADY, qids.size());
            end
        end
`ifndef W_REG_SLICE_EN
        if (Busy && qids.size() > 0) begin
            total++;
            if (S_WREADY[qids[0]] !== M_WREADY) begin
                bad++;
                $display("FAIL wready_mirror: S_WREADY=%b M_WREADY=%b", S_WREADY, M_WREADY);
            end
        end
`endif
        if (Busy && S_WVALID[0] && !S_WREADY[0] && stall_hs < 0) stall_hs = hs_count;
        if (S_WVALID[0] && S_WREADY[0]) begin
            void'(mq0.pop_front());
            hs_count++; last_m_hs = cyc;
            if (first_m < 0) first_m = cyc;
        end
        if (S_WVALID[1] && S_WREADY[1]) begin
            void'(mq1.pop_front());
            hs_count++; last_m_hs = cyc;
            if (first_m < 0) first_m = cyc;
        end
        if (M_WVALID && M_WREADY) begin
            total++;
            if (first_s < 0) first_s = cyc;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat_extra: got data=%h with nothing expected", M_WDATA);
            end else begin
                e = exp_q.pop_front();
                if ({M_WDATA, M_WSTRB, M_WLAST} !== e) begin
                    bad++;
                    $display("FAIL beat_data: got %h/%h/%b want %h/%h/%b",
                             M_WDATA, M_WSTRB, M_WLAST, e.data, e.strb, e.last);
                end
            end
        end
        if (Write_Data_Finsh) begin
            finsh_count++;
            prev_fin = last_fin;
            last_fin = cyc;
            if (qids.size() > 0) void'(qids.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((qids.size() > 0 || mq0.size() > 0 || mq1.size() > 0 || exp_q.size() > 0 ||
                Busy || Write_Data_Finsh) && n < budget) begin
            step();
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL drain_timeout: exp left=%0d after %0d cycles", exp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        step();
        step();
        total++;
        if ({Busy, Write_Data_Finsh, S_WREADY, M_WVALID, M_WLAST, M_WDATA, M_WSTRB, Beat_Count} !== 50'd0) begin
            bad++;
            $display("FAIL reset_vals: busy=%b fin=%b wr=%b mv=%b cnt=%0d", Busy, Write_Data_Finsh,
                     S_WREADY, M_WVALID, Beat_Count);
        end
        ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (Busy !== 1'b0 || finsh_count != 0 || M_WVALID !== 1'b0) begin
            bad++;
            $display("FAIL idle_stays: busy=%b fins=%0d mv=%b want 0/0/0", Busy, finsh_count, M_WVALID);
        end
    endtask

    task automatic test_single_burst();
        int f0 = finsh_count;
        first_m = -1; first_s = -1;
        qids.push_back(1'b0);
        for (int i = 0; i < 4; i++) add_beat(0, 32'hA0 + i, i == 3);
        drain(40);
        total++;
        if (Beat_Count !== 9'd4) begin
            bad++; $display("FAIL single_count: got %0d want 4", Beat_Count);
        end
        total++;
        if (finsh_count - f0 != 1 || last_fin != last_m_hs + 1) begin
            bad++;
            $display("FAIL single_finsh: pulses=%0d at %0d last beat %0d want 1 at +1",
                     finsh_count - f0, last_fin, last_m_hs);
        end
        total++;
        if (first_s - first_m != LAT) begin
            bad++; $display("FAIL single_latency: got %0d want %0d", first_s - first_m, LAT);
        end
    endtask

    task automatic test_ordering();
        int f0 = finsh_count;
        qids.push_back(1'b0);
        qids.push_back(1'b1);
        add_beat(0, 32'hC0, 1'b0);
        add_beat(0, 32'hC1, 1'b1);
        add_beat(1, 32'hB0, 1'b1);
        drain(40);
        total++;
        if (finsh_count - f0 != 2) begin
            bad++; $display("FAIL order_finsh: got %0d pulses want 2", finsh_count - f0);
        end
        total++;
        if (Beat_Count !== 9'd1) begin
            bad++; $display("FAIL order_count: got %0d want 1", Beat_Count);
        end
    endtask

    task automatic test_backpressure();
        qids.push_back(1'b1);
        for (int i = 0; i < 3; i++) add_beat(1, 32'h5D00 + i, i == 2);
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        drain(40);
        total++;
        if (Beat_Count !== 9'd3) begin
            bad++; $display("FAIL bp_count: got %0d want 3", Beat_Count);
        end
    endtask

    task automatic test_back_to_back();
        int f0 = finsh_count;
        qids.push_back(1'b0);
        qids.push_back(1'b1);
        add_beat(0, 32'h11, 1'b1);
        add_beat(1, 32'h22, 1'b1);
        drain(40);
        total++;
        if (finsh_count - f0 != 2 || last_fin - prev_fin != 3) begin
            bad++;
            $display("FAIL b2b_spacing: pulses=%0d gap=%0d want 2 and 3", finsh_count - f0, last_fin - prev_fin);
        end
        total++;
        if (Beat_Count !== 9'd1) begin
            bad++; $display("FAIL b2b_count: got %0d want 1", Beat_Count);
        end
    endtask

    task automatic test_reset_mid();
        int base = hs_count;
        int f0 = finsh_count;
        int n = 0;
        qids.push_back(1'b0);
        for (int i = 0; i < 4; i++) add_beat(0, 32'hD0 + i, i == 3);
        while (hs_count - base < 2 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (hs_count - base != 2) begin
            bad++; $display("FAIL midrst_setup: got %0d beats want 2", hs_count - base);
        end
        mq0.delete(); exp_q.delete(); qids.delete();
        ARESETN = 1'b0;
        rdy_pat.push_back(1'b0);
        step();
        total++;
        if ({Busy, Beat_Count, S_WREADY, M_WVALID, Write_Data_Finsh} !== 13'd0) begin
            bad++;
            $display("FAIL midrst_vals: busy=%b cnt=%0d wr=%b mv=%b fin=%b want zeros",
                     Busy, Beat_Count, S_WREADY, M_WVALID, Write_Data_Finsh);
        end
        step();
        ARESETN = 1'b1;
        step();
        step();
        total++;
        if (finsh_count != f0 || Busy !== 1'b0) begin
            bad++; $display("FAIL midrst_nofinsh: pulses=%0d busy=%b want 0/0", finsh_count - f0, Busy);
        end
    endtask

`ifdef W_REG_SLICE_EN
    task automatic test_skid();
        int base = hs_count;
        stall_hs = -1;
        qids.push_back(1'b0);
        for (int i = 0; i < 4; i++) add_beat(0, 32'hE0 + i, i == 3);
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b0};
        drain(40);
        total++;
        if (stall_hs - base != 2) begin
            bad++; $display("FAIL skid_full: stalled after %0d beats want 2", stall_hs - base);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_ordering();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef W_REG_SLICE_EN
        test_skid();
`endif
        test_single_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_wdata_mux_ctrl.md
Name: axi_wdata_mux_ctrl

Overview:
- Consumer side of the write-data master-ID queue in the AXI4 interconnect write path.
- Pops the queue head (Master_Valid / Write_Data_Master) and locks the W channel of that master onto the slave-side W port.
- Forwards beats until the WLAST handshake, then pulses Write_Data_Finsh so the queue advances to the next granted master.
- Enforces AW-order W routing with no W interleaving.

Parameters:
Masters_Num, 2, number of master-side W ports
ID_Size, $clog2(Masters_Num), width of master index
Data_Width, 32, WDATA width; WSTRB width = Data_Width/8
Cnt_Width, 9, beat counter width (AXI4 maximum is 256 beats)

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
Master_Valid  in  1  queue head valid
Write_Data_Master  in  ID_Size  queue head master index
Write_Data_Finsh  out  1  one-cycle pulse, pops queue
S_WDATA  in  Masters_Num*Data_Width  packed master WDATA, master i at slice i
S_WSTRB  in  Masters_Num*Data_Width/8  packed master WSTRB
S_WLAST  in  Masters_Num  per-master WLAST
S_WVALID  in  Masters_Num  per-master WVALID
S_WREADY  out  Masters_Num  per-master WREADY
M_WDATA  out  Data_Width  slave-side WDATA
M_WSTRB  out  Data_Width/8  slave-side WSTRB
M_WLAST  out  1  slave-side WLAST
M_WVALID  out  1  slave-side WVALID
M_WREADY  in  1  slave-side WREADY
Beat_Count  out  Cnt_Width  beats accepted in current burst
Busy  out  1  high in LOCK state

Behaviour:
- Clocking and reset: all state updates on posedge ACLK. ARESETN is sampled at the clock edge.
- Reset values: state=IDLE, sel=0, Beat_Count=0, Write_Data_Finsh=0, Busy=0, S_WREADY=0, M_WVALID=0, M_WLAST=0, M_WDATA=0, M_WSTRB=0.
- FSM states: IDLE, LOCK, DONE.
- IDLE: if Master_Valid=1, latch sel<=Write_Data_Master, clear Beat_Count, go to LOCK. Otherwise stay in IDLE. All S_WREADY and M_WVALID are 0.
- LOCK:
  - Busy=1.
  - M_WVALID=S_WVALID[sel]; M_WDATA, M_WSTRB and M_WLAST come from slice sel.
  - S_WREADY[sel]=M_WREADY; all other S_WREADY bits are 0.
  - This path is combinational, so a beat transfers in the same cycle.
  - On each handshake (M_WVALID & M_WREADY): Beat_Count increments, saturating at all-ones.
  - Handshake with M_WLAST=1: go to DONE and register Write_Data_Finsh=1 for the next cycle only.
- DONE:
  - Write_Data_Finsh=1 for exactly this cycle.
  - All READY and VALID outputs are 0.
  - Next state is IDLE unconditionally, so the queue head is re-sampled only after it has updated.
- Per-burst overhead: 2 idle cycles (IDLE and DONE). Latency from Master_Valid rising to first possible beat: 1 cycle.
- A non-selected master asserting WVALID is held off with WREADY=0 and is never dropped.
- Write_Data_Master changing while in LOCK is ignored; sel stays latched.
- Master_Valid=0 in IDLE: remain idle indefinitely.
- Single-beat burst (WLAST on first beat): Beat_Count=1, then DONE.
- Reset mid-burst: next edge returns to IDLE with reset values. A partially forwarded burst is abandoned, and no Finsh pulse is emitted.

Optional Feature:
- Macro W_REG_SLICE_EN.
- Defined: a two-entry skid buffer is inserted between the mux and the M_W* outputs.
  - M_W* outputs are fully registered; first-beat latency is +1 cycle.
  - Throughput stays 1 beat/cycle.
  - S_WREADY[sel] = skid not full.
  - Beat_Count counts master-side handshakes.
  - DONE is entered on the master-side WLAST handshake.
  - The DONE-to-IDLE transition does not wait for the skid to drain. A following burst's beats queue behind the buffered ones, preserving order.
  - Reset empties the buffer.
- Undefined: combinational pass-through as described in Behaviour.

Test Plan:
- Single burst, sel=0: Master_Valid=1, Write_Data_Master=0; master0 sends 4 beats 0xA0..0xA3 with WLAST on the 4th; M_WREADY=1. Expect M_WDATA sequence A0..A3, Beat_Count=4, Write_Data_Finsh high exactly 1 cycle after the last beat, S_WREADY[1]=0 throughout.
- Ordering: queue presents 0, then 1 after Finsh. Master1 holds WVALID with data 0xB0 during master0's 2-beat burst. Expect 0xB0 not forwarded until master0 completes; then B0 forwarded, second Finsh pulse.
- Backpressure: M_WREADY toggles 1,0,0,1,1 during a 3-beat burst. Expect no beat lost or duplicated, S_WREADY[sel] mirrors M_WREADY, Beat_Count=3 at finish.
- Single-beat burst with immediate next queue entry: two consecutive 1-beat bursts. Expect IDLE-LOCK-DONE-IDLE-LOCK-DONE, two Finsh pulses 3 cycles apart.
- Reset mid-burst: ARESETN=0 after beat 2 of a 4-beat burst. Expect at the next edge: Busy=0, Beat_Count=0, all READY/VALID=0, no Finsh pulse.
- W_REG_SLICE_EN build: repeat scenario 1. Expect M_WDATA delayed by 1 cycle and the same data sequence with M_WREADY held at 1. Then stall M_WREADY=0 for 3 cycles: S_WREADY[0] drops after 2 buffered beats.
